dcache_mem_ctrl: RTL and testbench

// - Sits between dcache miss/evict outputs and the shared 64-bit memory port.
// - Queues write-through (wr), read-miss (rd) and dirty-writeback (wb) requests in one in-order FIFO.
// - Issues the queued requests to memory one per grant and tracks outstanding loads by memory tag.
// - Returns line fills to dcache (mem_wr_*) and load completions (rd_gnt) to the LSQ.

---
 rtl/dcache_mem_ctrl_if.sv | 67 ++++++
 rtl/dcache_mem_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_dcache_mem_ctrl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_mem_ctrl_if.sv
// Bus bundle between dcache/LSQ, the memory controller and the shared 64-bit memory port.
// slave = controller side, master = dcache + memory side.
`ifndef LSQSZ
`define LSQSZ 8
`endif

interface dcache_mem_ctrl_if #(
  parameter int LSQSZ = `LSQSZ
);
  logic             wr_en_in;
  logic [15:0]      wr_addr_in;
  logic [63:0]      wr_data_in;
  logic [1:0]       wr_size_in;

  logic             rd_en_in;
  logic [15:0]      rd_addr_in;
  logic [1:0]       rd_size_in;
  logic [LSQSZ-1:0] rd_gnt_in;

  logic             wb_en_in;
  logic [15:0]      wb_addr_in;
  logic [63:0]      wb_data_in;
  logic [1:0]       wb_size_in;

  logic             req_ready;
  logic             overflow_err;

  logic [1:0]       proc2mem_command;
  logic [15:0]      proc2mem_addr;
  logic [63:0]      proc2mem_data;
  logic [1:0]       proc2mem_size;
  logic             mem_grant;
  logic [3:0]       mem2proc_response;
  logic [3:0]       mem2proc_tag;
  logic [63:0]      mem2proc_data;

  logic             mem_wr_en;
  logic [4:0]       mem_wr_idx;
  logic [7:0]       mem_wr_tag;
  logic [63:0]      mem_wr_data;

  logic             ld_done_en;
  logic [LSQSZ-1:0] ld_done_gnt;
  logic [63:0]      ld_done_data;

  modport slave (
    input  wr_en_in, wr_addr_in, wr_data_in, wr_size_in,
    input  rd_en_in, rd_addr_in, rd_size_in, rd_gnt_in,
    input  wb_en_in, wb_addr_in, wb_data_in, wb_size_in,
    output req_ready, overflow_err,
    output proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size,
    input  mem_grant, mem2proc_response, mem2proc_tag, mem2proc_data,
    output mem_wr_en, mem_wr_idx, mem_wr_tag, mem_wr_data,
    output ld_done_en, ld_done_gnt, ld_done_data
  );

  modport master (
    output wr_en_in, wr_addr_in, wr_data_in, wr_size_in,
    output rd_en_in, rd_addr_in, rd_size_in, rd_gnt_in,
    output wb_en_in, wb_addr_in, wb_data_in, wb_size_in,
    input  req_ready, overflow_err,
    input  proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size,
    output mem_grant, mem2proc_response, mem2proc_tag, mem2proc_data,
    input  mem_wr_en, mem_wr_idx, mem_wr_tag, mem_wr_data,
    input  ld_done_en, ld_done_gnt, ld_done_data
  );
endinterface

// File: rtl/dcache_mem_ctrl.sv
// In-order request FIFO + outstanding-load table between dcache misses/evictions and memory.
// Optional DCACHE_MEM_CTRL_PERF_EN adds saturating load/store/busy counters.
`ifndef LSQSZ
`define LSQSZ 8
`endif

module dcache_mem_ctrl #(
  parameter int REQ_DEPTH       = 8,
  parameter int MAX_OUTSTANDING = 8,
  parameter int LSQSZ           = `LSQSZ
) (
  input  logic                    clock,
  input  logic                    reset,
  dcache_mem_ctrl_if.slave        bus
`ifdef DCACHE_MEM_CTRL_PERF_EN
  ,
  output logic [31:0]             perf_loads,
  output logic [31:0]             perf_stores,
  output logic [31:0]             perf_busy
`endif
);

  localparam int IDX_W = $clog2(REQ_DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [1:0] CMD_NONE  = 2'd0;
  localparam logic [1:0] CMD_LOAD  = 2'd1;
  localparam logic [1:0] CMD_STORE = 2'd2;

  typedef struct packed {
    logic             is_load;
    logic [15:0]      addr;
    logic [63:0]      data;
    logic [1:0]       size;
    logic [LSQSZ-1:0] gnt;
  } req_t;

  req_t             r_fifo [REQ_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic             r_overflow;

  logic [15:0]      r_tbl_vld;
  logic [12:0]      r_tbl_line [16];
  logic [LSQSZ-1:0] r_tbl_gnt  [16];
  logic [CNT_W-1:0] r_out_cnt;

  logic             r_ret_en;
  logic [4:0]       r_ret_idx;
  logic [7:0]       r_ret_tag;
  logic [63:0]      r_ret_data;
  logic [LSQSZ-1:0] r_ret_gnt;

  logic [PTR_W-1:0] w_used;
  logic [PTR_W-1:0] w_free;
  logic             w_empty;
  logic             w_full;

  req_t             w_src      [3];
  logic [2:0]       w_src_en;
  logic [2:0]       w_push_ok;
  logic [PTR_W-1:0] w_push_ptr [3];
  logic [PTR_W-1:0] w_push_cnt;
  logic             w_drop;

  req_t             w_head;
  logic             w_cap_hit;
  logic             w_drive;
  logic             w_accept;
  logic             w_acc_load;
  logic             w_ret;

  // Occupancy from the extra-MSB pointers; full when MSBs differ and the index bits match.
  assign w_used  = r_wr_ptr - r_rd_ptr;
  assign w_free  = PTR_W'(REQ_DEPTH) - w_used;
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PTR_W-1] != r_rd_ptr[PTR_W-1]) &&
                   (r_wr_ptr[PTR_W-2:0] == r_rd_ptr[PTR_W-2:0]);

  assign bus.req_ready    = (w_free >= PTR_W'(3)) && !w_full;
  assign bus.overflow_err = r_overflow;

  // Sources are packed into consecutive slots in wr, rd, wb order; whatever does not fit is dropped.
  always_comb begin
    w_src[0]   = '{1'b0, bus.wr_addr_in, bus.wr_data_in, bus.wr_size_in, {LSQSZ{1'b0}}};
    w_src[1]   = '{1'b1, bus.rd_addr_in, 64'd0,          bus.rd_size_in, bus.rd_gnt_in};
    w_src[2]   = '{1'b0, bus.wb_addr_in, bus.wb_data_in, bus.wb_size_in, {LSQSZ{1'b0}}};
    w_src_en   = {bus.wb_en_in, bus.rd_en_in, bus.wr_en_in};
    w_push_cnt = '0;
    w_drop     = 1'b0;
    for (int k = 0; k < 3; k++) begin
      w_push_ok[k]  = 1'b0;
      w_push_ptr[k] = r_wr_ptr + w_push_cnt;
      if (w_src_en[k]) begin
        if (w_push_cnt < w_free) begin
          w_push_ok[k] = 1'b1;
          w_push_cnt   = w_push_cnt + PTR_W'(1);
        end else begin
          w_drop = 1'b1;
        end
      end
    end
  end

  assign w_head     = r_fifo[r_rd_ptr[IDX_W-1:0]];
  assign w_cap_hit  = (r_out_cnt == CNT_W'(MAX_OUTSTANDING));
  assign w_drive    = !w_empty && bus.mem_grant && !(w_head.is_load && w_cap_hit);
  assign w_accept   = w_drive && (bus.mem2proc_response != 4'd0);
  assign w_acc_load = w_accept && w_head.is_load;
  assign w_ret      = (bus.mem2proc_tag != 4'd0) && r_tbl_vld[bus.mem2proc_tag];

  always_comb begin
    bus.proc2mem_command = CMD_NONE;
    bus.proc2mem_addr    = '0;
    bus.proc2mem_data    = '0;
    bus.proc2mem_size    = '0;
    if (w_drive) begin
      bus.proc2mem_command = w_head.is_load ? CMD_LOAD : CMD_STORE;
      bus.proc2mem_addr    = w_head.addr;
      bus.proc2mem_data    = w_head.data;
      bus.proc2mem_size    = w_head.size;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_wr_ptr <= r_wr_ptr + w_push_cnt;
      if (w_accept) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_drop)   r_overflow <= 1'b1;
    end
  end

  // Payload storage needs no reset: slots are only read between push and pop.
  always_ff @(posedge clock) begin
    for (int k = 0; k < 3; k++) begin
      if (w_push_ok[k]) r_fifo[w_push_ptr[k][IDX_W-1:0]] <= w_src[k];
    end
  end

  // Invalidate before allocate so a same-tag accept in the return cycle keeps the new entry.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_tbl_vld <= '0;
      r_out_cnt <= '0;
    end else begin
      if (w_ret)      r_tbl_vld[bus.mem2proc_tag]      <= 1'b0;
      if (w_acc_load) r_tbl_vld[bus.mem2proc_response] <= 1'b1;
      if (w_acc_load && !w_ret)      r_out_cnt <= r_out_cnt + CNT_W'(1);
      else if (!w_acc_load && w_ret) r_out_cnt <= r_out_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (w_acc_load) begin
      r_tbl_line[bus.mem2proc_response] <= w_head.addr[15:3];
      r_tbl_gnt[bus.mem2proc_response]  <= w_head.gnt;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ret_en   <= 1'b0;
      r_ret_idx  <= '0;
      r_ret_tag  <= '0;
      r_ret_data <= '0;
      r_ret_gnt  <= '0;
    end else begin
      r_ret_en <= w_ret;
      if (w_ret) begin
        r_ret_idx  <= r_tbl_line[bus.mem2proc_tag][4:0];
        r_ret_tag  <= r_tbl_line[bus.mem2proc_tag][12:5];
        r_ret_data <= bus.mem2proc_data;
        r_ret_gnt  <= r_tbl_gnt[bus.mem2proc_tag];
      end else begin
        r_ret_idx  <= '0;
        r_ret_tag  <= '0;
        r_ret_data <= '0;
        r_ret_gnt  <= '0;
      end
    end
  end

  assign bus.mem_wr_en    = r_ret_en;
  assign bus.mem_wr_idx   = r_ret_idx;
  assign bus.mem_wr_tag   = r_ret_tag;
  assign bus.mem_wr_data  = r_ret_data;
  assign bus.ld_done_en   = r_ret_en;
  assign bus.ld_done_gnt  = r_ret_gnt;
  assign bus.ld_done_data = r_ret_data;

`ifdef DCACHE_MEM_CTRL_PERF_EN
  logic [31:0] r_perf_loads;
  logic [31:0] r_perf_stores;
  logic [31:0] r_perf_busy;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_perf_loads  <= '0;
      r_perf_stores <= '0;
      r_perf_busy   <= '0;
    end else begin
      if (w_acc_load && (r_perf_loads != 32'hFFFF_FFFF))
        r_perf_loads <= r_perf_loads + 32'd1;
      if (w_accept && !w_head.is_load && (r_perf_stores != 32'hFFFF_FFFF))
        r_perf_stores <= r_perf_stores + 32'd1;
      if (w_drive && !w_accept && (r_perf_busy != 32'hFFFF_FFFF))
        r_perf_busy <= r_perf_busy + 32'd1;
    end
  end

  assign perf_loads  = r_perf_loads;
  assign perf_stores = r_perf_stores;
  assign perf_busy   = r_perf_busy;
`endif

endmodule

// File: tb/tb_dcache_mem_ctrl.sv
// Directed bench for dcache_mem_ctrl: store/load paths, ordering, retry, outstanding cap, overflow, reset.
`ifndef LSQSZ
`define LSQSZ 8
`endif

module tb_dcache_mem_ctrl;
  logic clock;
  logic reset;
  int   checks;
  int   failures;

  dcache_mem_ctrl_if #(.LSQSZ(8)) bus ();

  dcache_mem_ctrl #(.REQ_DEPTH(8), .MAX_OUTSTANDING(8), .LSQSZ(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clr();
    bus.wr_en_in = 0; bus.wr_addr_in = '0; bus.wr_data_in = '0; bus.wr_size_in = '0;
    bus.rd_en_in = 0; bus.rd_addr_in = '0; bus.rd_size_in = '0; bus.rd_gnt_in = '0;
    bus.wb_en_in = 0; bus.wb_addr_in = '0; bus.wb_data_in = '0; bus.wb_size_in = '0;
    bus.mem_grant = 0; bus.mem2proc_response = '0; bus.mem2proc_tag = '0; bus.mem2proc_data = '0;
  endtask

  task automatic test_reset();
    clr();
    reset = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    step();
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0h exp=1", bus.req_ready); end
    checks++; if (bus.overflow_err !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%0h exp=0", bus.overflow_err); end
    checks++; if (bus.proc2mem_command !== 2'd0) begin failures++; $display("FAIL reset_cmd got=%0h exp=0", bus.proc2mem_command); end
    checks++; if (bus.mem_wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%0h exp=0", bus.mem_wr_en); end
    checks++; if (bus.ld_done_en !== 1'b0) begin failures++; $display("FAIL reset_ld_done got=%0h exp=0", bus.ld_done_en); end
    bus.mem_grant = 1;
    #1;
    checks++; if (bus.proc2mem_command !== 2'd0) begin failures++; $display("FAIL reset_empty_cmd got=%0h exp=0", bus.proc2mem_command); end
    step(); clr();
  endtask

  task automatic test_store_accept();
    bus.wr_en_in = 1; bus.wr_addr_in = 16'h1238; bus.wr_data_in = 64'hAB; bus.wr_size_in = 2'd0;
    step(); clr();
    bus.mem_grant = 1; bus.mem2proc_response = 4'd3;
    #1;
    checks++; if (bus.proc2mem_command !== 2'd2) begin failures++; $display("FAIL store_cmd got=%0h exp=2", bus.proc2mem_command); end
    checks++; if (bus.proc2mem_addr !== 16'h1238) begin failures++; $display("FAIL store_addr got=%0h exp=1238", bus.proc2mem_addr); end
    checks++; if (bus.proc2mem_data !== 64'hAB) begin failures++; $display("FAIL store_data got=%0h exp=ab", bus.proc2mem_data); end
    step(); clr();
    bus.mem_grant = 1;
    #1;
    checks++; if (bus.proc2mem_command !== 2'd0) begin failures++; $display("FAIL store_fifo_empty got=%0h exp=0", bus.proc2mem_command); end
    checks++; if (bus.mem_wr_en !== 1'b0) begin failures++; $display("FAIL store_no_fill got=%0h exp=0", bus.mem_wr_en); end
    step(); clr();
    bus.mem2proc_tag = 4'd3; bus.mem2proc_data = 64'h55;
    step(); clr();
    checks++; if (bus.mem_wr_en !== 1'b0) begin failures++; $display("FAIL store_tag_ignored got=%0h exp=0", bus.mem_wr_en); end
  endtask

  task automatic test_load_roundtrip();
    bus.rd_en_in = 1; bus.rd_addr_in = 16'h0A40; bus.rd_size_in = 2'd3; bus.rd_gnt_in = 8'h04;
    step(); clr();
    bus.mem_grant = 1; bus.mem2proc_response = 4'd5;
    #1;
    checks++; if (bus.proc2mem_command !== 2'd1) begin failures++; $display("FAIL load_cmd got=%0h exp=1", bus.proc2mem_command); end
    checks++; if (bus.proc2mem_addr !== 16'h0A40) begin failures++; $display("FAIL load_addr got=%0h exp=a40", bus.proc2mem_addr); end
    checks++; if (bus.proc2mem_size !== 2'd3) begin failures++; $display("FAIL load_size got=%0h exp=3", bus.proc2mem_size); end
    step(); clr();
    step();
    checks++; if (bus.mem_wr_en !== 1'b0) begin failures++; $display("FAIL load_no_early_fill got=%0h exp=0", bus.mem_wr_en); end
    bus.mem2proc_tag = 4'd5; bus.mem2proc_data = 64'hDEAD;
    step(); clr();
    checks++; if (bus.mem_wr_en !== 1'b1) begin failures++; $display("FAIL load_wr_en got=%0h exp=1", bus.mem_wr_en); end
    checks++; if (bus.mem_wr_idx !== 5'd8) begin failures++; $display("FAIL load_idx got=%0h exp=8", bus.mem_wr_idx); end
    checks++; if (bus.mem_wr_tag !== 8'h0A) begin failures++; $display("FAIL load_tag got=%0h exp=0a", bus.mem_wr_tag); end
    checks++; if (bus.mem_wr_data !== 64'hDEAD) begin failures++; $display("FAIL load_fill_data got=%0h exp=dead", bus.mem_wr_data); end
    checks++; if (bus.ld_done_en !== 1'b1) begin failures++; $display("FAIL load_done_en got=%0h exp=1", bus.ld_done_en); end
    checks++; if (bus.ld_done_gnt !== 8'h04) begin failures++; $display("FAIL load_done_gnt got=%0h exp=04", bus.ld_done_gnt); end
    checks++; if (bus.ld_done_data !== 64'hDEAD) begin failures++; $display("FAIL load_done_data got=%0h exp=dead", bus.ld_done_data); end
    step();
    checks++; if (bus.mem_wr_en !== 1'b0) begin failures++; $display("FAIL load_pulse_end got=%0h exp=0", bus.mem_wr_en); end
    bus.mem2proc_tag = 4'd5; bus.mem2proc_data = 64'hBEEF;
    step(); clr();
    checks++; if (bus.ld_done_en !== 1'b0) begin failures++; $display("FAIL load_stale_return got=%0h exp=0", bus.ld_done_en); end
  endtask

  task automatic test_three_push();
    bus.wr_en_in = 1; bus.wr_addr_in = 16'h1000; bus.wr_data_in = 64'h1;
    bus.rd_en_in = 1; bus.rd_addr_in = 16'h2008; bus.rd_gnt_in = 8'h01;
    bus.wb_en_in = 1; bus.wb_addr_in = 16'h3010; bus.wb_data_in = 64'h3; bus.wb_size_in = 2'd3;
    step(); clr();
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL three_ready got=%0h exp=1", bus.req_ready); end
    bus.mem_grant = 1; bus.mem2proc_response = 4'd1;
    #1;
    checks++; if (bus.proc2mem_command !== 2'd2 || bus.proc2mem_addr !== 16'h1000) begin failures++; $display("FAIL three_first got=%0h/%0h exp=2/1000", bus.proc2mem_command, bus.proc2mem_addr); end
    step(); clr();
    bus.mem_grant = 1; bus.mem2proc_response = 4'd2;
    #1;
    checks++; if (bus.proc2mem_command !== 2'd1 || bus.proc2mem_addr !== 16'h2008) begin failures++; $display("FAIL three_second got=%0h/%0h exp=1/2008", bus.proc2mem_command, bus.proc2mem_addr); end
    step(); clr();
    bus.mem_grant = 1; bus.mem2proc_response = 4'd3;
    #1;
    checks++; if (bus.proc2mem_command !== 2'd2 || bus.proc2mem_addr !== 16'h3010 || bus.proc2mem_data !== 64'h3) begin failures++; $display("FAIL three_third got=%0h/%0h/%0h exp=2/3010/3", bus.proc2mem_command, bus.proc2mem_addr, bus.proc2mem_data); end
    step(); clr();
    bus.mem_grant = 1;
    #1;
    checks++; if (bus.proc2mem_command !== 2'd0) begin failures++; $display("FAIL three_drained got=%0h exp=0", bus.proc2mem_command); end
    step(); clr();
    bus.mem2proc_tag = 4'd2; bus.mem2proc_data = 64'h77;
    step(); clr();
    checks++; if (bus.ld_done_en !== 1'b1 || bus.ld_done_gnt !== 8'h01) begin failures++; $display("FAIL three_ret got=%0h/%0h exp=1/01", bus.ld_done_en, bus.ld_done_gnt); end
  endtask

  task automatic test_busy();
    bus.wr_en_in = 1; bus.wr_addr_in = 16'h4444; bus.wr_data_in = 64'h44;
    step(); clr();
    for (int i = 0; i < 2; i++) begin
      bus.mem_grant = 1; bus.mem2proc_response = 4'd0;
      #1;
      checks++; if (bus.proc2mem_command !== 2'd2 || bus.proc2mem_addr !== 16'h4444) begin failures++; $display("FAIL busy_redrive%0d got=%0h/%0h exp=2/4444", i, bus.proc2mem_command, bus.proc2mem_addr); end
      step(); clr();
    end
    bus.mem_grant = 0; bus.mem2proc_response = 4'd7;
    #1;
    checks++; if (bus.proc2mem_command !== 2'd0) begin failures++; $display("FAIL busy_nogrant got=%0h exp=0", bus.proc2mem_command); end
    step(); clr();
    bus.mem_grant = 1; bus.mem2proc_response = 4'd7;
    #1;
    checks++; if (bus.proc2mem_command !== 2'd2) begin failures++; $display("FAIL busy_accept got=%0h exp=2", bus.proc2mem_command); end
    step(); clr();
    bus.mem_grant = 1;
    #1;
    checks++; if (bus.proc2mem_command !== 2'd0) begin failures++; $display("FAIL busy_drained got=%0h exp=0", bus.proc2mem_command); end
    step(); clr();
  endtask

  task automatic test_back_to_back();
    bus.wr_en_in = 1; bus.wr_addr_in = 16'h5000;
    step(); clr();
    bus.mem_grant = 1; bus.mem2proc_response = 4'd1;
    bus.wr_en_in = 1; bus.wr_addr_in = 16'h6000;
    #1;
    checks++; if (bus.proc2mem_addr !== 16'h5000) begin failures++; $display("FAIL b2b_first got=%0h exp=5000", bus.proc2mem_addr); end
    step(); clr();
    bus.mem_grant = 1; bus.mem2proc_response = 4'd1;
    #1;
    checks++; if (bus.proc2mem_command !== 2'd2 || bus.proc2mem_addr !== 16'h6000) begin failures++; $display("FAIL b2b_second got=%0h/%0h exp=2/6000", bus.proc2mem_command, bus.proc2mem_addr); end
    step(); clr();
    bus.rd_en_in = 1; bus.rd_addr_in = 16'h0100; bus.rd_gnt_in = 8'h01;
    step(); clr();
    bus.mem_grant = 1; bus.mem2proc_response = 4'd4;
    step(); clr();
    bus.rd_en_in = 1; bus.rd_addr_in = 16'h0208; bus.rd_gnt_in = 8'h02;
    step(); clr();
    bus.mem_grant = 1; bus.mem2proc_response = 4'd4;
    bus.mem2proc_tag = 4'd4; bus.mem2proc_data = 64'h11;
    step(); clr();
    checks++; if (bus.ld_done_en !== 1'b1 || bus.ld_done_gnt !== 8'h01) begin failures++; $display("FAIL b2b_old_ret got=%0h/%0h exp=1/01", bus.ld_done_en, bus.ld_done_gnt); end
    bus.mem2proc_tag = 4'd4; bus.mem2proc_data = 64'h22;
    step(); clr();
    checks++; if (bus.ld_done_en !== 1'b1 || bus.ld_done_gnt !== 8'h02) begin failures++; $display("FAIL b2b_new_wins got=%0h/%0h exp=1/02", bus.ld_done_en, bus.ld_done_gnt); end
    checks++; if (bus.mem_wr_idx !== 5'd1 || bus.mem_wr_tag !== 8'h02) begin failures++; $display("FAIL b2b_new_line got=%0h/%0h exp=1/02", bus.mem_wr_idx, bus.mem_wr_tag); end
  endtask

  task automatic test_outstanding_cap();
    for (int i = 0; i < 8; i++) begin
      bus.rd_en_in = 1; bus.rd_addr_in = 16'h0100 + 16'(i * 16); bus.rd_gnt_in = 8'(1 << i);
      step(); clr();
      bus.mem_grant = 1; bus.mem2proc_response = 4'(i + 1);
      #1;
      checks++; if (bus.proc2mem_command !== 2'd1) begin failures++; $display("FAIL cap_load%0d got=%0h exp=1", i, bus.proc2mem_command); end
      step(); clr();
    end
    bus.rd_en_in = 1; bus.rd_addr_in = 16'h0900; bus.rd_gnt_in = 8'h80;
    step(); clr();
    bus.mem_grant = 1; bus.mem2proc_response = 4'd9;
    #1;
    checks++; if (bus.proc2mem_command !== 2'd0) begin failures++; $display("FAIL cap_blocked got=%0h exp=0", bus.proc2mem_command); end
    bus.mem2proc_tag = 4'd3; bus.mem2proc_data = 64'h33;
    #1;
    checks++; if (bus.proc2mem_command !== 2'd0) begin failures++; $display("FAIL cap_ret_cycle got=%0h exp=0", bus.proc2mem_command); end
    step(); clr();
    checks++; if (bus.ld_done_gnt !== 8'h04) begin failures++; $display("FAIL cap_ret_gnt got=%0h exp=04", bus.ld_done_gnt); end
    bus.mem_grant = 1; bus.mem2proc_response = 4'd9;
    #1;
    checks++; if (bus.proc2mem_command !== 2'd1 || bus.proc2mem_addr !== 16'h0900) begin failures++; $display("FAIL cap_release got=%0h/%0h exp=1/900", bus.proc2mem_command, bus.proc2mem_addr); end
    step(); clr();
  endtask

  task automatic test_overflow_reset();
    for (int c = 0; c < 2; c++) begin
      bus.wr_en_in = 1; bus.wr_addr_in = 16'h7000;
      bus.rd_en_in = 1; bus.rd_addr_in = 16'h7100;
      bus.wb_en_in = 1; bus.wb_addr_in = 16'h7200;
      step(); clr();
      checks++; if (bus.req_ready !== (c == 0)) begin failures++; $display("FAIL ovf_ready%0d got=%0h exp=%0h", c, bus.req_ready, (c == 0)); end
    end
    bus.wr_en_in = 1; bus.wr_addr_in = 16'h7300;
    bus.rd_en_in = 1; bus.rd_addr_in = 16'h7400;
    step(); clr();
    checks++; if (bus.overflow_err !== 1'b0) begin failures++; $display("FAIL ovf_full_no_err got=%0h exp=0", bus.overflow_err); end
    bus.wr_en_in = 1; bus.wr_addr_in = 16'h7500;
    step(); clr();
    checks++; if (bus.overflow_err !== 1'b1) begin failures++; $display("FAIL ovf_set got=%0h exp=1", bus.overflow_err); end
    step();
    checks++; if (bus.overflow_err !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%0h exp=1", bus.overflow_err); end
    bus.mem_grant = 1;
    #1;
    checks++; if (bus.proc2mem_command !== 2'd2 || bus.proc2mem_addr !== 16'h7000) begin failures++; $display("FAIL ovf_head got=%0h/%0h exp=2/7000", bus.proc2mem_command, bus.proc2mem_addr); end
    reset = 1'b0;
    #1;
    checks++; if (bus.proc2mem_command !== 2'd0) begin failures++; $display("FAIL rst_cmd got=%0h exp=0", bus.proc2mem_command); end
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%0h exp=1", bus.req_ready); end
    checks++; if (bus.overflow_err !== 1'b0) begin failures++; $display("FAIL rst_ovf got=%0h exp=0", bus.overflow_err); end
    step(); clr();
    reset = 1'b1;
    step();
    bus.mem2proc_tag = 4'd2; bus.mem2proc_data = 64'h99;
    step(); clr();
    checks++; if (bus.mem_wr_en !== 1'b0) begin failures++; $display("FAIL rst_stale_ret got=%0h exp=0", bus.mem_wr_en); end
    bus.mem_grant = 1;
    #1;
    checks++; if (bus.proc2mem_command !== 2'd0) begin failures++; $display("FAIL rst_fifo_empty got=%0h exp=0", bus.proc2mem_command); end
    step(); clr();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    clr();
    test_reset();
    test_store_accept();
    test_load_roundtrip();
    test_three_push();
    test_busy();
    test_back_to_back();
    test_outstanding_cap();
    test_overflow_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
